// File: rtl/joypad_poller.sv
// Polls nes_bridge at a fixed rate, latches completed samples as active-high buttons,
// and keeps sticky press/release flags with a maskable level interrupt.
module joypad_poller #(
    parameter int unsigned POLL_PERIOD = 833_333,
    parameter int unsigned TIMEOUT     = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        bridge_start_o,
    output logic [1:0]  bridge_addr_o,
    input  logic [7:0]  bridge_rdata_i,
    input  logic [1:0]  bus_addr_i,
    input  logic        bus_wen_i,
    input  logic [7:0]  bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        irq_o
);

    localparam int unsigned PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST       = TW'(TIMEOUT - 1);

    localparam logic [1:0] A_READY = 2'b00;
    localparam logic [1:0] A_VALID = 2'b01;
    localparam logic [1:0] A_JOY   = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_REQ,
        S_BUSY,
        S_CHECK,
        S_LATCH
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] to_q, to_d;
    logic          blank_q, blank_d;
    logic [7:0]    buttons_q, buttons_d;
    logic          have_q, have_d;
    logic          err_q, err_d;
    logic [7:0]    press_q, press_d;
    logic [7:0]    rel_q, rel_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          irq_q, irq_d;
    logic [1:0]    addr_q, addr_d;

    logic          start;
    logic [7:0]    new_btn;
    logic [7:0]    press_set, rel_set;
    logic [7:0]    press_clr, rel_clr;
    logic          wr_status, wr_press, wr_rel, wr_ctrl;

    assign wr_status = bus_wen_i && (bus_addr_i == 2'd0);
    assign wr_press  = bus_wen_i && (bus_addr_i == 2'd1);
    assign wr_rel    = bus_wen_i && (bus_addr_i == 2'd2);
    assign wr_ctrl   = bus_wen_i && (bus_addr_i == 2'd3);

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        to_d      = to_q;
        blank_d   = blank_q;
        buttons_d = buttons_q;
        have_d    = have_q;
        err_d     = err_q;
        press_set = '0;
        rel_set   = '0;
        start     = 1'b0;
        new_btn   = ~bridge_rdata_i;

        // Clear is applied first so a timeout raised in the same cycle wins.
        if (wr_status && bus_wdata_i[1]) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_WAIT: begin
                to_d = '0;
                if (!ctrl_q[0]) begin
                    period_d = PERIOD_RELOAD;
                end else if (period_q == '0) begin
                    period_d = PERIOD_RELOAD;
                    state_d  = S_REQ;
                end else begin
                    period_d = period_q - 1'b1;
                end
            end
            S_REQ: begin
                if (bridge_rdata_i[0]) begin
                    start   = 1'b1;
                    to_d    = '0;
                    blank_d = 1'b1;
                    state_d = S_BUSY;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_BUSY: begin
                // Ready is ignored on the first cycle; the bridge has not yet dropped it.
                if (!blank_q && bridge_rdata_i[0]) begin
                    state_d = S_CHECK;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    to_d    = to_q + 1'b1;
                    blank_d = 1'b0;
                end
            end
            S_CHECK: begin
                state_d = bridge_rdata_i[0] ? S_LATCH : S_WAIT;
            end
            S_LATCH: begin
                if (have_q) begin
                    press_set = new_btn & ~buttons_q;
                    rel_set   = ~new_btn & buttons_q;
                end
                buttons_d = new_btn;
                have_d    = 1'b1;
                state_d   = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        press_clr = wr_press ? bus_wdata_i : '0;
        rel_clr   = wr_rel ? bus_wdata_i : '0;
        press_d   = (press_q & ~press_clr) | press_set;
        rel_d     = (rel_q & ~rel_clr) | rel_set;
        ctrl_d    = wr_ctrl ? bus_wdata_i[2:0] : ctrl_q;
        irq_d     = ((|press_q) & ctrl_q[1]) | ((|rel_q) & ctrl_q[2]);

        case (state_d)
            S_CHECK: addr_d = A_VALID;
            S_LATCH: addr_d = A_JOY;
            default: addr_d = A_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            period_q  <= PERIOD_RELOAD;
            to_q      <= '0;
            blank_q   <= 1'b0;
            buttons_q <= '0;
            have_q    <= 1'b0;
            err_q     <= 1'b0;
            press_q   <= '0;
            rel_q     <= '0;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
            addr_q    <= A_READY;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            to_q      <= to_d;
            blank_q   <= blank_d;
            buttons_q <= buttons_d;
            have_q    <= have_d;
            err_q     <= err_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
            addr_q    <= addr_d;
        end
    end

    assign bridge_start_o = start;
    assign bridge_addr_o  = addr_q;
    assign irq_o          = irq_q;

    always_comb begin
        bus_rdata_o = '0;
        case (bus_addr_i)
            2'd0: bus_rdata_o = {21'd0, (state_q != S_WAIT), err_q, have_q, buttons_q};
            2'd1: bus_rdata_o = {24'd0, press_q};
            2'd2: bus_rdata_o = {24'd0, rel_q};
            default: bus_rdata_o = {29'd0, ctrl_q};
        endcase
    end

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a small behavioural nes_bridge read port.
module tb_joypad_poller;

    localparam int unsigned PP = 16;
    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bridge_start;
    logic [1:0]  bridge_addr;
    logic [7:0]  bridge_rdata;
    logic [1:0]  bus_addr;
    logic        bus_wen;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    joypad_poller #(.POLL_PERIOD(PP), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bridge_start_o(bridge_start),
        .bridge_addr_o (bridge_addr),
        .bridge_rdata_i(bridge_rdata),
        .bus_addr_i    (bus_addr),
        .bus_wen_i     (bus_wen),
        .bus_wdata_i   (bus_wdata),
        .bus_rdata_o   (bus_rdata),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    // Bridge model: ready drops for a few cycles after each start.
    logic        stall = 1'b0;
    logic        valid = 1'b1;
    logic [7:0]  joy   = 8'hFF;
    int unsigned bcnt  = 0;
    logic        ready;

    always @(posedge clk) begin
        if (bridge_start) bcnt <= 4;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always_comb begin
        ready = (bcnt == 0) && !stall;
        case (bridge_addr)
            2'b00:   bridge_rdata = {7'd0, ready};
            2'b01:   bridge_rdata = {7'd0, valid};
            default: bridge_rdata = joy;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
        @(negedge clk);
        bus_wen = 1'b0; bus_addr = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_addr = a;
        #1 d = bus_rdata;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bridge_start === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        bus_addr = 2'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus_rdata[10] === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic poll(input string tag);
        logic ok;
        wait_start(ok);
        chk({tag, "_start"}, 32'(ok), 32'd1);
        wait_idle(ok);
        chk({tag, "_idle"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [7:0]  joy;
        logic        valid;
        logic [31:0] exp_status;
        logic [7:0]  exp_press;
        logic [7:0]  exp_rel;
        logic        exp_irq;
        logic [7:0]  w1c_p;
        logic [7:0]  w1c_r;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] d;
        logic        ok;
        int          n, starts;

        vecs[0] = '{3'd1, 8'hFE, 1'b1, 32'h101, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{3'd3, 8'hFC, 1'b1, 32'h103, 8'h02, 8'h00, 1'b1, 8'h02, 8'h00};
        vecs[2] = '{3'd5, 8'hFF, 1'b1, 32'h100, 8'h00, 8'h03, 1'b1, 8'h00, 8'h03};
        vecs[3] = '{3'd7, 8'h5A, 1'b0, 32'h100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{3'd7, 8'h5A, 1'b1, 32'h1A5, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'h00};
        vecs[5] = '{3'd1, 8'h0F, 1'b1, 32'h1F0, 8'h50, 8'h05, 1'b0, 8'h50, 8'h05};
        vecs[6] = '{3'd3, 8'h0F, 1'b1, 32'h1F0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

        rst_n = 1'b0; bus_addr = 2'd0; bus_wen = 1'b0; bus_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(bridge_start), 32'd0);
        chk("rst_addr", 32'(bridge_addr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        rd(2'd0, d); chk("rst_status", d, 32'h0);
        rd(2'd3, d); chk("rst_ctrl", d, 32'h0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bridge_start) n++;
        end
        chk("no_start_disabled", 32'(n), 32'd0);

        for (int v = 0; v < 7; v++) begin
            wr(2'd3, {5'd0, vecs[v].ctrl});
            joy = vecs[v].joy; valid = vecs[v].valid;
            poll($sformatf("v%0d", v));
            rd(2'd0, d); chk($sformatf("v%0d_status", v), d, vecs[v].exp_status);
            rd(2'd1, d); chk($sformatf("v%0d_press", v), d, 32'(vecs[v].exp_press));
            rd(2'd2, d); chk($sformatf("v%0d_rel", v), d, 32'(vecs[v].exp_rel));
            chk($sformatf("v%0d_irq", v), 32'(irq), 32'(vecs[v].exp_irq));
            if (vecs[v].w1c_p != 8'h00) wr(2'd1, vecs[v].w1c_p);
            if (vecs[v].w1c_r != 8'h00) wr(2'd2, vecs[v].w1c_r);
        end

        // W1C of PRESS: flag clears on the write edge, irq one edge later.
        wr(2'd3, 8'h03);
        joy = 8'h0E;
        poll("h1");
        rd(2'd0, d); chk("h1_status", d, 32'h1F1);
        rd(2'd1, d); chk("h1_press", d, 32'h01);
        chk("h1_irq", 32'(irq), 32'd1);
        wr(2'd1, 8'h01);
        bus_addr = 2'd1;
        #1 chk("h1_press_clr", bus_rdata, 32'h0);
        chk("h1_irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("h1_irq_clr", 32'(irq), 32'd0);

        // Release flags, then a W1C landing on the latch cycle of a new release.
        wr(2'd3, 8'h05);
        joy = 8'hFF;
        poll("h2a");
        rd(2'd2, d); chk("h2a_rel", d, 32'hF1);
        chk("h2a_irq", 32'(irq), 32'd1);
        joy = 8'hFE;
        poll("h2b");
        rd(2'd1, d); chk("h2b_press", d, 32'h01);
        joy = 8'hFF;
        wait_start(ok);
        chk("h2c_start", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bridge_addr == 2'b10) begin ok = 1'b1; break; end
        end
        chk("h2c_latch_seen", 32'(ok), 32'd1);
        bus_addr = 2'd2; bus_wdata = 8'hF1; bus_wen = 1'b1;
        @(negedge clk);
        bus_wen = 1'b0;
        rd(2'd2, d); chk("h2c_rel_setwins", d, 32'h01);
        rd(2'd0, d); chk("h2c_status", d, 32'h100);

        // Timeout: ready held low for TIMEOUT cycles in S_REQ.
        wr(2'd3, 8'h01);
        stall = 1'b1;
        bus_addr = 2'd0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (bus_rdata[10]) begin ok = 1'b1; break; end
        end
        chk("to_req_seen", 32'(ok), 32'd1);
        n = 0; starts = 0;
        for (int i = 0; i < 100; i++) begin
            if (bridge_start) starts++;
            if (!bus_rdata[10]) break;
            n++;
            @(negedge clk); #1;
        end
        chk("to_req_cycles", 32'(n), 32'(TO));
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus_rdata[10]) break;
            n++;
            @(negedge clk); #1;
        end
        chk("to_wait_cycles", 32'(n), 32'(PP));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bridge_start) starts++;
        end
        chk("to_no_start", 32'(starts), 32'd0);
        rd(2'd0, d); chk("to_status", {22'd0, d[9:0]}, 32'h300);
        wr(2'd0, 8'h01);
        rd(2'd0, d); chk("to_err_kept", 32'(d[9]), 32'd1);
        wr(2'd0, 8'h02);
        rd(2'd0, d); chk("to_err_clr", 32'(d[9]), 32'd0);
        stall = 1'b0;
        poll("to_resume");
        rd(2'd0, d); chk("to_resume_status", d, 32'h100);

        // Asynchronous reset while in S_BUSY.
        wr(2'd3, 8'h07);
        wait_start(ok);
        chk("rb_start", 32'(ok), 32'd1);
        @(negedge clk);
        chk("rb_irq_pre", 32'(irq), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_start0", 32'(bridge_start), 32'd0);
        chk("rb_addr0", 32'(bridge_addr), 32'd0);
        chk("rb_irq0", 32'(irq), 32'd0);
        bus_addr = 2'd0;
        #1 chk("rb_status0", bus_rdata, 32'h0);
        bus_addr = 2'd1;
        #1 chk("rb_press0", bus_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bridge_start) n++;
        end
        chk("rb_no_start", 32'(n), 32'd0);
        wr(2'd3, 8'h01);
        poll("rb_first");
        rd(2'd0, d); chk("rb_first_status", d, 32'h100);
        rd(2'd1, d); chk("rb_first_press", d, 32'h0);
        rd(2'd2, d); chk("rb_first_rel", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Memory-mapped front end for `nes_bridge` that sits directly upstream of it on the CPU side. It periodically issues bridge start pulses and time-multiplexes the bridge's `rdata_addr` read port to collect each completed sample. Each sample is converted to active-high button state and produces sticky press/release event flags and an interrupt. It is the only agent that drives the bridge's `start` and `rdata_addr`.

## Interface
- `POLL_PERIOD`, 833_333: clock cycles between poll requests (60 Hz at 50 MHz); must be ≥ 2.
- `TIMEOUT`, 2_000_000: maximum cycles to wait for the bridge to return ready before abandoning a sample.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bridge_start`  out  1  one-cycle start pulse to `nes_bridge`.
- `bridge_addr`  out  2  drives bridge `rdata_addr` (00 ready, 01 joypad_valid, 1x joypad).
- `bridge_rdata`  in  8  bridge `rdata`, combinational on `bridge_addr`.
- `bus_addr`  in  2  register word index (byte offset / 4).
- `bus_wen`  in  1  register write strobe, one cycle.
- `bus_wdata`  in  8  write data.
- `bus_rdata`  out  32  combinational read data for `bus_addr`, upper bits zero.
- `irq`  out  1  level interrupt.

## Operation
- Registers:
  - 0 STATUS (RO): [7:0] buttons, active-high = ~joypad; [8] have_sample; [9] timeout_err (sticky, W1C via bit 1 of CTRL write? no — cleared by writing STATUS with bit 1 set); [10] busy (FSM not in S_WAIT).
  - 1 PRESS (W1C): [7:0] sticky rising-edge flags.
  - 2 RELEASE (W1C): [7:0] sticky falling-edge flags.
  - 3 CTRL (RW): [0] enable, [1] press_ie, [2] release_ie.
- Writes to STATUS: `bus_wdata[1]`=1 clears timeout_err; other bits are ignored.
- Reset values: buttons 0, have_sample 0, timeout_err 0, PRESS/RELEASE 0, CTRL 0, `bridge_start` 0, `bridge_addr` 00, `irq` 0, period counter POLL_PERIOD-1, state S_WAIT.
- FSM:
  - S_WAIT: `bridge_addr`=00. The period counter decrements only while enable=1. At 0 it reloads POLL_PERIOD-1 and goes to S_REQ. Clearing enable holds the counter, then reloads it on re-enable.
  - S_REQ: `bridge_addr`=00. If `bridge_rdata[0]`=1, assert `bridge_start` this cycle, clear the timeout counter, and go to S_BUSY. Otherwise stay; the timeout counter runs here too.
  - S_BUSY: `bridge_addr`=00. The first cycle is always ignored (blank cycle). Afterwards, `bridge_rdata[0]`=1 goes to S_CHECK.
  - S_CHECK: `bridge_addr`=01. If `bridge_rdata[0]`=1, go to S_LATCH. Otherwise go to S_WAIT with no update (bridge aborted).
  - S_LATCH: `bridge_addr`=10. Set new=~`bridge_rdata`.
    - If have_sample=1: PRESS |= new & ~buttons and RELEASE |= ~new & buttons.
    - Then buttons<=new, have_sample<=1, go to S_WAIT.
  - Timeout: in S_REQ/S_BUSY, if the timeout counter reaches TIMEOUT-1, set timeout_err and go to S_WAIT.
    - The bridge is not reset. The next S_REQ waits for ready, so no start is issued while the bridge is busy.
- A poll request that arrives while disabled is not issued. Disabling mid-poll lets the current poll finish.
- First sample after reset produces no events. have_sample is never cleared except by reset.
- Simultaneous W1C write and event set on the same bit in the same cycle: set wins (flag remains 1).
- `irq` = (|PRESS & press_ie) | (|RELEASE & release_ie), registered; it updates one cycle after the flags or CTRL change.
- Counter widths: $clog2 of the respective parameter. No wrap beyond the reload value.

## Timing
- `bridge_start` is high exactly one cycle per poll and only in S_REQ with observed ready=1.
- `bridge_addr` changes only on state change, so `bridge_rdata` is stable for the full cycle it is sampled.
- Bridge completion to registers: S_BUSY sees ready → S_CHECK (+1) → S_LATCH (+2). buttons/PRESS/RELEASE are visible on `bus_rdata` at +3, and `irq` at +4.
- Register writes take effect on the next clock edge. Reads are combinational and same-cycle.
- Poll spacing is POLL_PERIOD cycles of enabled time measured S_WAIT-exit to S_WAIT-exit, plus bridge latency.

## Test plan
- Reset, CTRL=1, bridge model returns joypad 8'hFE: one `bridge_start` pulse → STATUS=0x101, PRESS=0, `irq`=0.
- Second sample 8'hFC with press_ie=1 → buttons=0x03, PRESS=0x02, `irq`=1. Write PRESS=0x02 → PRESS=0, `irq`=0 two cycles later.
- Sample 8'hFF after 8'hFC with release_ie=1 → RELEASE=0x03 and `irq`=1. W1C on the same cycle as a new release on bit 0 → bit 0 stays 1.
- Bridge holds ready=0 for TIMEOUT cycles → STATUS[9]=1, no latch, no extra `bridge_start` until ready=1. Write STATUS bit1 → [9]=0.
- Bridge returns ready with joypad_valid=0 → buttons unchanged, no events, back to S_WAIT.
- Assert rst_n low in S_BUSY → all outputs at reset values immediately. `bridge_start` stays 0 until enable is rewritten.
